// File: rtl/adventure_room_fsm.sv
// Room-navigation FSM for the adventure game: tracks the player's room from
// edge-detected N/S/E/W presses, drives sw for the sword FSM and resolves the Dragon's Den.
module adventure_room_fsm #(
    parameter int MOVE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    input  logic              v,
    output logic              sw,
    output logic [6:0]        room,
    output logic              win,
    output logic              dead,
    output logic [MOVE_W-1:0] moves
);

    localparam logic [6:0] CAVE   = 7'b0000001;
    localparam logic [6:0] TUNNEL = 7'b0000010;
    localparam logic [6:0] RIVER  = 7'b0000100;
    localparam logic [6:0] STASH  = 7'b0001000;
    localparam logic [6:0] DEN    = 7'b0010000;
    localparam logic [6:0] VAULT  = 7'b0100000;
    localparam logic [6:0] GRAVE  = 7'b1000000;

    localparam logic [MOVE_W-1:0] MOVES_MAX = {MOVE_W{1'b1}};

    logic [6:0]        room_q,  room_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic [3:0]        btn_q,   btn_d;
    logic              arm_q,   arm_d;
    logic [3:0]        press;
    logic              go_n, go_s, go_e, go_w;
    logic              moved;

    // Button bit order is {n,s,e,w}.
    assign btn_d = {n, s, e, w};
    assign arm_d = 1'b1;

    // Presses are masked for the first edge after reset release so that a
    // button held through reset cannot masquerade as a fresh press.
    always_comb begin
        press = btn_d & ~btn_q & {4{arm_q}};
        go_n  = (press == 4'b1000);
        go_s  = (press == 4'b0100);
        go_e  = (press == 4'b0010);
        go_w  = (press == 4'b0001);
    end

    // State register, edge-detect copies and move counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            room_q  <= CAVE;
            moves_q <= '0;
            btn_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            room_q  <= room_d;
            moves_q <= moves_d;
            btn_q   <= btn_d;
            arm_q   <= arm_d;
        end
    end

    // Next-state logic.
    always_comb begin
        room_d = room_q;
        moved  = 1'b0;
        unique case (room_q)
            CAVE: begin
                if (go_e) begin
                    room_d = TUNNEL;
                    moved  = 1'b1;
                end
            end
            TUNNEL: begin
                if (go_w) begin
                    room_d = CAVE;
                    moved  = 1'b1;
                end else if (go_s) begin
                    room_d = RIVER;
                    moved  = 1'b1;
                end
            end
            RIVER: begin
                if (go_n) begin
                    room_d = TUNNEL;
                    moved  = 1'b1;
                end else if (go_w) begin
                    room_d = STASH;
                    moved  = 1'b1;
                end else if (go_e) begin
                    room_d = DEN;
                    moved  = 1'b1;
                end
            end
            STASH: begin
                if (go_e) begin
                    room_d = RIVER;
                    moved  = 1'b1;
                end
            end
            DEN: begin
                room_d = v ? VAULT : GRAVE;
                moved  = 1'b1;
            end
            VAULT, GRAVE: begin
                room_d = room_q;
            end
            default: begin
                // Corrupted state: fall back to the start room without counting a move.
                room_d = CAVE;
            end
        endcase
    end

    always_comb begin
        moves_d = moves_q;
        if (moved && (moves_q != MOVES_MAX)) begin
            moves_d = moves_q + MOVE_W'(1);
        end
    end

    // Output decode, purely from registered state.
    always_comb begin
        room  = room_q;
        sw    = room_q[3];
        win   = room_q[5];
        dead  = room_q[6];
        moves = moves_q;
    end

endmodule
